// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: 2**FIFO_AW-byte FIFO feeding an 8N1 shifter, LSB first, idle-high txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module uart_tx_fifo #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_AW  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [7:0]         wdata,
  input  logic               clr_ovf,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               busy,
  output logic               ovf,
  output logic               txd
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]    BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  state_t             state_q, state_d;
  logic [CW-1:0]      baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic push;
  logic pop;
  logic bit_end;

  // Status decodes from the registered count only, so a same-cycle pop never frees a slot.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign busy  = (state_q != S_IDLE);
  assign ovf   = ovf_q;
  assign txd   = txd_q;

  assign push    = wr && !full;
  assign bit_end = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      shift_d    = mem_q[rd_ptr_q];
      baud_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d   = ^mem_q[rd_ptr_q];
`endif
    end
  end

  // txd follows the registered state, so the line lags the state by one cycle.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_q;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with BAUD_DIV=4, FIFO_AW=3.
module tb_uart_tx_fifo;
  localparam int BD = 4;
  localparam int AW = 3;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * BD;
`else
  localparam int FRAME = 10 * BD;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr = 1'b0;
  logic [7:0]   wdata = 8'h00;
  logic         clr_ovf = 1'b0;
  logic         full, empty, busy, ovf, txd;
  logic [AW:0]  count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wdata(wdata), .clr_ovf(clr_ovf),
    .full(full), .empty(empty), .count(count), .busy(busy), .ovf(ovf), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       wr;
    logic [7:0] wdata;
    logic       clr;
    logic       e_txd;
    logic       e_busy;
    logic [3:0] e_count;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Waits for a start bit, samples mid-bit, checks start/parity/stop framing.
  task automatic rx_byte(output logic [7:0] b, output int t0);
    int n = 0;
    b = 8'h00;
    while (txd !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    t0 = cyc;
    if (n >= 200) begin
      chk("rx_start_timeout", 32'(n), 32'd0);
    end else begin
      repeat (2) step();
      chk("rx_start_bit", 32'(txd), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) step();
        b[i] = txd;
      end
`ifdef UART_TX_PARITY_EN
      repeat (BD) step();
      chk("rx_parity_bit", 32'(txd), 32'(^b));
`endif
      repeat (BD) step();
      chk("rx_stop_bit", 32'(txd), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp_b;
    int t[4];

    // wr, wdata, clr, txd, busy, count, full, ovf
    tbl[0]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h16, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h17, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h18, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h19, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h1A, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h1B, 1'b0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 8'h1C, 1'b0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 8'h1D, 1'b1, 1'b1, 1'b1, 4'd8, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);

    // Single byte, cycle exact
    wr = 1'b1; wdata = 8'hA5;
    step();
    wr = 1'b0;
    chk("single_push_count", 32'(count), 32'd1);
    chk("single_push_busy", 32'(busy), 32'd0);
    chk("single_push_txd", 32'(txd), 32'd1);
    step();
    chk("single_pop_busy", 32'(busy), 32'd1);
    chk("single_pop_empty", 32'(empty), 32'd1);
    chk("single_pop_txd", 32'(txd), 32'd1);
    for (int k = 0; k < FRAME; k++) begin
      step();
      chk($sformatf("single_txd_c%0d", k), 32'(txd), 32'(frame_bit(8'hA5, k / BD)));
      chk($sformatf("single_busy_c%0d", k), 32'(busy), 32'(k < FRAME - 1));
    end

    // Back-to-back frames with no idle gap
    fork
      begin
        wr = 1'b1; wdata = 8'h00; step();
        chk("b2b_count0", 32'(count), 32'd1);
        wdata = 8'hFF; step();
        chk("b2b_count1", 32'(count), 32'd1);
        wdata = 8'h55; step();
        chk("b2b_count_peak", 32'(count), 32'd2);
        wr = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          rx_byte(b, t[k]);
          exp_b = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h55;
          chk($sformatf("b2b_byte%0d", k), 32'(b), 32'(exp_b));
        end
      end
    join
    chk("b2b_gap01", 32'(t[1] - t[0]), 32'(FRAME));
    chk("b2b_gap12", 32'(t[2] - t[1]), 32'(FRAME));
    chk("b2b_empty", 32'(empty), 32'd1);
    repeat (3) step();
    chk("b2b_idle", 32'(busy), 32'd0);

    // Overflow table: first byte popped, 8 queued, extra pushes dropped
    for (int j = 0; j < 13; j++) begin
      wr = tbl[j].wr; wdata = tbl[j].wdata; clr_ovf = tbl[j].clr;
      step();
      chk($sformatf("ovf_txd_r%0d", j), 32'(txd), 32'(tbl[j].e_txd));
      chk($sformatf("ovf_busy_r%0d", j), 32'(busy), 32'(tbl[j].e_busy));
      chk($sformatf("ovf_count_r%0d", j), 32'(count), 32'(tbl[j].e_count));
      chk($sformatf("ovf_full_r%0d", j), 32'(full), 32'(tbl[j].e_full));
      chk($sformatf("ovf_ovf_r%0d", j), 32'(ovf), 32'(tbl[j].e_ovf));
    end
    wr = 1'b0; clr_ovf = 1'b0;
    repeat (FRAME - 11) step();
    chk("ovf_second_pop_count", 32'(count), 32'd7);
    chk("ovf_second_pop_full", 32'(full), 32'd0);
    for (int k = 0; k < 8; k++) begin
      rx_byte(b, t[0]);
      chk($sformatf("ovf_byte%0d", k), 32'(b), 32'(8'h14 + 8'(k)));
    end
    repeat (3) step();
    chk("ovf_drained_empty", 32'(empty), 32'd1);
    chk("ovf_drained_busy", 32'(busy), 32'd0);

    // Pointer wrap: 20 bytes in bursts of 5
    for (int burst = 0; burst < 4; burst++) begin
      fork
        begin
          for (int k = 0; k < 5; k++) begin
            wr = 1'b1; wdata = 8'(8'd3 + 8'((burst * 5 + k) * 29));
            step();
          end
          wr = 1'b0;
        end
        begin
          for (int k = 0; k < 5; k++) begin
            rx_byte(b, t[0]);
            chk($sformatf("wrap_b%0d_k%0d", burst, k), 32'(b),
                32'(8'd3 + 8'((burst * 5 + k) * 29)));
          end
        end
      join
    end
    repeat (3) step();
    chk("wrap_empty", 32'(empty), 32'd1);

`ifdef UART_TX_PARITY_EN
    fork
      begin
        wr = 1'b1; wdata = 8'h07; step();
        wdata = 8'h03; step();
        wr = 1'b0;
      end
      begin
        rx_byte(b, t[0]);
        chk("par_byte07", 32'(b), 32'h07);
        rx_byte(b, t[1]);
        chk("par_byte03", 32'(b), 32'h03);
      end
    join
    chk("par_frame_len", 32'(t[1] - t[0]), 32'd44);
    chk("par_bit07", 32'(^8'h07), 32'(frame_bit(8'h07, 9)));
    repeat (3) step();
`endif

    // Reset mid-frame
    wr = 1'b1; wdata = 8'hC3; step();
    wdata = 8'h3C; step();
    wr = 1'b0;
    step(); step();
    chk("midrst_pre_txd", 32'(txd), 32'd0);
    chk("midrst_pre_count", 32'(count), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_txd", 32'(txd), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("midrst_after_txd", 32'(txd), 32'd1);
    chk("midrst_after_busy", 32'(busy), 32'd0);
    chk("midrst_after_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
